// File: rtl/solver_dispatcher.sv
// Host-side dispatcher for the interleaved endgame solver: stages root boards, tracks the job
// tag held by each solver context and queues (tag, score) results behind a credit limit.
module solver_dispatcher #(
    parameter int NCTX   = 7,
    parameter int TAGW   = 8,
    parameter int RDEPTH = 8
) (
    input  logic            iCLOCK,
    input  logic            inRESET,
    input  logic            iRun,
    input  logic            iJobValid,
    output logic            oJobReady,
    input  logic [63:0]     iJobPlayer,
    input  logic [63:0]     iJobOpponent,
    input  logic [TAGW-1:0] iJobTag,
    output logic            oResValid,
    input  logic            iResReady,
    output logic [TAGW-1:0] oResTag,
    output logic [7:0]      oResScore,
    output logic            oEnable,
    output logic [63:0]     oPlayer,
    output logic [63:0]     oOpponent,
    input  logic            iSolved,
    input  logic [7:0]      iRes,
    input  logic [3:0]      iCtx,
    output logic            oBusy
);

    localparam int CW = $clog2(NCTX);
    localparam int OW = $clog2(NCTX + 1);
    localparam int FW = $clog2(RDEPTH);
    localparam int SW = ((OW > FW + 1) ? OW : FW + 1) + 1;
    localparam logic [63:0] DUMMY_P = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_enable;
    logic              r_out_en;
    logic [CW-1:0]     r_cnt;
    logic              r_stg_valid;
    logic [63:0]       r_stg_p;
    logic [63:0]       r_stg_o;
    logic [TAGW-1:0]   r_stg_tag;
    logic [NCTX-1:0]   r_live;
    logic [TAGW-1:0]   r_tag [NCTX];
    logic [OW-1:0]     r_outstanding;
    logic [TAGW-1:0]   r_fifo_tag [RDEPTH];
    logic [7:0]        r_fifo_score [RDEPTH];
    logic [FW-1:0]     r_wptr;
    logic [FW-1:0]     r_rptr;
    logic [FW:0]       r_fcount;

    logic              w_ctx_ok;
    logic [CW-1:0]     w_ctx;
    logic              w_take;
    logic              w_credit_ok;
    logic              w_present;
    logic              w_take_real;
    logic              w_push;
    logic              w_pop;
    logic              w_accept;
    logic              w_full;

    assign w_ctx_ok    = (iCtx < 4'(NCTX));
    assign w_ctx       = (r_state == S_START) ? r_cnt : iCtx[CW-1:0];
    assign w_take      = (r_state == S_START) | ((r_state == S_RUN) & iSolved & w_ctx_ok);
    // Every live job or queued result holds a FIFO slot, so a finishing job always has room.
    assign w_credit_ok = (SW'(r_outstanding) + SW'(r_fcount)) < SW'(RDEPTH);
    assign w_present   = r_stg_valid & w_credit_ok & iRun;
    assign w_take_real = w_take & w_present;
    assign w_push      = (r_state == S_RUN) & iSolved & w_ctx_ok & r_live[w_ctx];
    assign w_pop       = (r_fcount != {(FW+1){1'b0}}) & iResReady;
    assign w_accept    = iJobValid & oJobReady;
    assign w_full      = (r_fcount == (FW+1)'(RDEPTH));

    assign oJobReady   = r_out_en & (~r_stg_valid | w_take_real);
    assign oPlayer     = w_present ? r_stg_p : DUMMY_P;
    assign oOpponent   = w_present ? r_stg_o : 64'h0;
    assign oResValid   = (r_fcount != {(FW+1){1'b0}});
    assign oResTag     = oResValid ? r_fifo_tag[r_rptr] : {TAGW{1'b0}};
    assign oResScore   = oResValid ? r_fifo_score[r_rptr] : 8'h00;
    assign oEnable     = r_enable;
    assign oBusy       = (r_state != S_IDLE);

    // Sequencer: prime every context once, then run until drained with nothing in flight.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state  <= S_IDLE;
            r_enable <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            r_out_en <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (iRun) begin
                        r_state  <= S_START;
                        r_enable <= 1'b1;
                        r_cnt    <= {CW{1'b0}};
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_START: begin
                    if (r_cnt == CW'(NCTX - 1)) begin
                        r_state <= S_RUN;
                        r_cnt   <= {CW{1'b0}};
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (!iRun && (r_outstanding == {OW{1'b0}}) && !iSolved) begin
                        r_state  <= S_IDLE;
                        r_enable <= 1'b0;
                    end else begin
                        r_state  <= S_RUN;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_enable <= 1'b0;
                    r_cnt    <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Single-entry staging register between the job port and the solver.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_stg_valid <= 1'b0;
            r_stg_p     <= 64'h0;
            r_stg_o     <= 64'h0;
            r_stg_tag   <= {TAGW{1'b0}};
        end else if (w_accept) begin
            r_stg_valid <= 1'b1;
            r_stg_p     <= iJobPlayer;
            r_stg_o     <= iJobOpponent;
            r_stg_tag   <= iJobTag;
        end else if (w_take_real) begin
            r_stg_valid <= 1'b0;
        end else begin
            r_stg_valid <= r_stg_valid;
        end
    end

    // Context tag table and count of real jobs currently inside the solver.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_live        <= {NCTX{1'b0}};
            r_outstanding <= {OW{1'b0}};
            for (int i = 0; i < NCTX; i++) begin
                r_tag[i] <= {TAGW{1'b0}};
            end
        end else begin
            if (w_take) begin
                r_live[w_ctx] <= w_take_real;
                r_tag[w_ctx]  <= r_stg_tag;
            end else begin
                r_live[w_ctx] <= r_live[w_ctx];
            end
            r_outstanding <= r_outstanding + OW'(w_take_real) - OW'(w_push);
        end
    end

    // Result FIFO pointers and occupancy.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_wptr   <= {FW{1'b0}};
            r_rptr   <= {FW{1'b0}};
            r_fcount <= {(FW+1){1'b0}};
        end else begin
            r_wptr <= w_push ? r_wptr + FW'(1) : r_wptr;
            r_rptr <= w_pop ? r_rptr + FW'(1) : r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_fcount <= r_fcount + (FW+1)'(1);
                2'b01:   r_fcount <= r_fcount - (FW+1)'(1);
                default: r_fcount <= r_fcount;
            endcase
        end
    end

    // Result FIFO storage.
    always_ff @(posedge iCLOCK) begin
        if (w_push) begin
            r_fifo_tag[r_wptr]   <= r_tag[w_ctx];
            r_fifo_score[r_wptr] <= iRes;
        end else begin
            r_fifo_tag[r_wptr]   <= r_fifo_tag[r_wptr];
        end
    end

    solver_dispatcher_chk u_chk (
        .i_clk    (iCLOCK),
        .i_rst_n  (inRESET),
        .i_push   (w_push),
        .i_full   (w_full),
        .i_solved (iSolved),
        .i_run    (r_state == S_RUN),
        .i_ctx_ok (w_ctx_ok)
    );

endmodule

// Protocol and invariant checks for solver_dispatcher.
module solver_dispatcher_chk (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_push,
    input logic i_full,
    input logic i_solved,
    input logic i_run,
    input logic i_ctx_ok
);

    a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && i_full));
    a_solved_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_solved |-> (i_run && i_ctx_ok));

endmodule

// File: tb/tb_solver_dispatcher.sv
// Randomized bench for solver_dispatcher: a model solver latches presented boards per context,
// finishes them at random and a reference queue predicts results in completion order.
module tb_solver_dispatcher;

    localparam int NCTX   = 7;
    localparam int TAGW   = 8;
    localparam int RDEPTH = 8;
    localparam logic [63:0] DUMMY_P = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            iCLOCK = 1'b0;
    logic            inRESET = 1'b0;
    logic            iRun = 1'b0;
    logic            iJobValid = 1'b0;
    logic            oJobReady;
    logic [63:0]     iJobPlayer = 64'h0;
    logic [63:0]     iJobOpponent = 64'h0;
    logic [TAGW-1:0] iJobTag = '0;
    logic            oResValid;
    logic            iResReady = 1'b0;
    logic [TAGW-1:0] oResTag;
    logic [7:0]      oResScore;
    logic            oEnable;
    logic [63:0]     oPlayer;
    logic [63:0]     oOpponent;
    logic            iSolved = 1'b0;
    logic [7:0]      iRes = 8'h0;
    logic [3:0]      iCtx = 4'h0;
    logic            oBusy;

    solver_dispatcher #(.NCTX(NCTX), .TAGW(TAGW), .RDEPTH(RDEPTH)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRun(iRun),
        .iJobValid(iJobValid), .oJobReady(oJobReady), .iJobPlayer(iJobPlayer),
        .iJobOpponent(iJobOpponent), .iJobTag(iJobTag),
        .oResValid(oResValid), .iResReady(iResReady), .oResTag(oResTag), .oResScore(oResScore),
        .oEnable(oEnable), .oPlayer(oPlayer), .oOpponent(oOpponent),
        .iSolved(iSolved), .iRes(iRes), .iCtx(iCtx), .oBusy(oBusy)
    );

    always #5 iCLOCK = ~iCLOCK;

    typedef struct packed {
        logic [63:0]     p;
        logic [63:0]     o;
        logic [TAGW-1:0] tag;
    } job_t;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [7:0]      score;
    } res_t;

    job_t            offer_q[$];
    job_t            disp_q[$];
    res_t            exp_q[$];
    logic            ctx_real [NCTX];
    logic [TAGW-1:0] ctx_tag [NCTX];

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt = 0;
    int n_acc = 0;
    int n_res = 0;
    int solve_pct = 0;
    int ready_pct = 100;
    int f_ctx = -1;
    int f_res = 0;
    int dummy_only = 0;
    int n_before = 0;
    logic run_req = 1'b0;
    logic [TAGW-1:0] next_tag = '0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int real_cnt();
        int n = 0;
        for (int c = 0; c < NCTX; c++) n += ctx_real[c] ? 1 : 0;
        return n;
    endfunction

    function automatic bit all_done();
        return (offer_q.size() == 0) && (disp_q.size() == 0) && (real_cnt() == 0) && (exp_q.size() == 0);
    endfunction

    task automatic clear_model();
        offer_q.delete();
        disp_q.delete();
        exp_q.delete();
        for (int c = 0; c < NCTX; c++) begin
            ctx_real[c] = 1'b0;
            ctx_tag[c]  = '0;
        end
        en_cnt = 0;
        n_acc  = 0;
        n_res  = 0;
    endtask

    task automatic add_jobs(input int n);
        job_t j;
        logic [31:0] hi;
        for (int i = 0; i < n; i++) begin
            hi    = $urandom();
            j.tag = next_tag;
            j.p   = {hi, 24'h0, next_tag};
            j.o   = {$urandom(), $urandom()};
            offer_q.push_back(j);
            next_tag = next_tag + 8'd1;
        end
    endtask

    // Model solver context c latches the board currently presented.
    task automatic latch_ctx(input int c);
        if (oPlayer == DUMMY_P && oOpponent == 64'h0) begin
            ctx_real[c] = 1'b0;
        end else begin
            ctx_real[c] = 1'b1;
            if (disp_q.size() == 0) begin
                chk_eq("disp_unexpected", oPlayer, DUMMY_P);
                ctx_tag[c] = oPlayer[7:0];
            end else begin
                chk_eq("disp_player", oPlayer, disp_q[0].p);
                chk_eq("disp_opponent", oOpponent, disp_q[0].o);
                ctx_tag[c] = disp_q[0].tag;
                void'(disp_q.pop_front());
            end
        end
    endtask

    task automatic step();
        int   c;
        res_t r;
        @(negedge iCLOCK);
        iRun    = run_req;
        iSolved = 1'b0;
        iCtx    = 4'h0;
        iRes    = 8'h0;
        if (oEnable && en_cnt >= NCTX) begin
            if (f_ctx >= 0) begin
                iSolved = 1'b1;
                iCtx    = 4'(f_ctx);
                iRes    = 8'(f_res);
                f_ctx   = -1;
            end else if ($urandom_range(0, 99) < solve_pct) begin
                c = $urandom_range(0, NCTX - 1);
                if (!(dummy_only != 0 && ctx_real[c])) begin
                    iSolved = 1'b1;
                    iCtx    = 4'(c);
                    iRes    = 8'($urandom_range(0, 128) - 64);
                end
            end
        end
        iResReady = ($urandom_range(0, 99) < ready_pct);
        if (offer_q.size() != 0) begin
            iJobValid    = 1'b1;
            iJobPlayer   = offer_q[0].p;
            iJobOpponent = offer_q[0].o;
            iJobTag      = offer_q[0].tag;
        end else begin
            iJobValid    = 1'b0;
        end
        #1;
        chk_eq("res_valid", oResValid, exp_q.size() != 0);
        if (oResValid && iResReady && exp_q.size() != 0) begin
            chk_eq("res_tag", oResTag, exp_q[0].tag);
            chk_eq("res_score", oResScore, exp_q[0].score);
            void'(exp_q.pop_front());
            n_res++;
        end
        if (oEnable) begin
            if (en_cnt < NCTX) begin
                latch_ctx(en_cnt);
                en_cnt++;
            end else if (iSolved) begin
                if (ctx_real[iCtx]) begin
                    r.tag   = ctx_tag[iCtx];
                    r.score = iRes;
                    exp_q.push_back(r);
                end
                latch_ctx(int'(iCtx));
            end
        end else begin
            en_cnt = 0;
        end
        if (iJobValid && oJobReady) begin
            disp_q.push_back(offer_q.pop_front());
            n_acc++;
        end
        chk_eq("credit", (real_cnt() + exp_q.size()) <= RDEPTH, 1'b1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget && !all_done(); k++) step();
        chk_eq(tag, all_done(), 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int k = 0; k < budget && oBusy; k++) step();
        chk_eq(tag, oBusy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        repeat (3) @(negedge iCLOCK);
        chk_eq("rst_enable", oEnable, 1'b0);
        chk_eq("rst_res_valid", oResValid, 1'b0);
        chk_eq("rst_job_ready", oJobReady, 1'b0);
        chk_eq("rst_busy", oBusy, 1'b0);
        chk_eq("rst_player", oPlayer, DUMMY_P);
        chk_eq("rst_opponent", oOpponent, 64'h0);
        inRESET = 1'b1;
        repeat (2) step();
        chk_eq("idle_job_ready", oJobReady, 1'b1);

        // Start-up with a single staged job tagged 5
        next_tag = 8'd5;
        add_jobs(1);
        step();
        run_req = 1'b1;
        for (int k = 0; k < 20 && en_cnt < NCTX; k++) step();
        chk_eq("start_len", en_cnt, NCTX);
        chk_eq("ctx0_live", ctx_real[0], 1'b1);
        chk_eq("ctx0_tag", ctx_tag[0], 8'd5);
        for (int c = 1; c < NCTX; c++) chk_eq("ctx_dummy", ctx_real[c], 1'b0);
        ready_pct = 0;
        f_ctx = 0;
        f_res = 12;
        step();
        step();
        chk_eq("t2_valid", oResValid, 1'b1);
        chk_eq("t2_tag", oResTag, 8'd5);
        chk_eq("t2_score", oResScore, 8'd12);

        // Dummy result is discarded
        ready_pct = 100;
        step();
        f_ctx = 1;
        f_res = 64;
        step();
        step();
        chk_eq("t3_no_push", oResValid, 1'b0);

        // Backpressure: results stall at the FIFO depth, nothing lost
        ready_pct = 0;
        solve_pct = 50;
        add_jobs(20);
        repeat (300) step();
        chk_eq("bp_queued", exp_q.size(), RDEPTH);
        chk_eq("bp_valid", oResValid, 1'b1);
        chk_eq("bp_inflight", real_cnt(), 0);
        ready_pct = 100;
        wait_done("bp_drain_timeout", 3000);
        chk_eq("bp_all_results", n_res, 21);

        // Mixed random traffic
        ready_pct = 60;
        solve_pct = 60;
        add_jobs(40);
        repeat (400) step();
        wait_done("mix_timeout", 3000);
        chk_eq("mix_count", n_res, n_acc);

        // Drain with three live jobs
        dummy_only = 1;
        add_jobs(3);
        for (int k = 0; k < 500 && (offer_q.size() != 0 || disp_q.size() != 0); k++) step();
        chk_eq("drain_live", real_cnt(), 3);
        n_before = n_res;
        run_req = 1'b0;
        dummy_only = 0;
        wait_idle("drain_idle_timeout", 2000);
        repeat (20) step();
        chk_eq("drain_results", n_res - n_before, 3);
        chk_eq("drain_enable", oEnable, 1'b0);
        chk_eq("drain_busy", oBusy, 1'b0);

        // Reset in the middle of RUN
        run_req = 1'b1;
        ready_pct = 50;
        add_jobs(10);
        repeat (40) step();
        @(negedge iCLOCK);
        #2;
        inRESET   = 1'b0;
        iSolved   = 1'b0;
        iJobValid = 1'b0;
        #1;
        chk_eq("mid_rst_enable", oEnable, 1'b0);
        chk_eq("mid_rst_res_valid", oResValid, 1'b0);
        chk_eq("mid_rst_job_ready", oJobReady, 1'b0);
        chk_eq("mid_rst_busy", oBusy, 1'b0);
        clear_model();
        @(negedge iCLOCK);
        inRESET = 1'b1;
        ready_pct = 0;
        add_jobs(12);
        repeat (300) step();
        chk_eq("post_rst_credit", exp_q.size(), RDEPTH);
        ready_pct = 100;
        wait_done("post_rst_drain_timeout", 3000);
        chk_eq("post_rst_count", n_res, 12);
        run_req = 1'b0;
        wait_idle("final_idle_timeout", 2000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
